chan_scan_mux: RTL and testbench

CHAN_SCAN_MUX -- requirements
Module: chan_scan_mux

---
 rtl/chan_scan_pkg.sv | 16 +
 rtl/chan_sel_mux.sv | 25 ++
 rtl/chan_scan_mux.sv | 165 ++++++++++++++++
 tb/tb_chan_scan_mux.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/chan_scan_pkg.sv
// Shared types and default sizing for the channel scan multiplexer.
package chan_scan_pkg;

  // Default configuration constants
  localparam int unsigned DEF_NUM_CH = 8;
  localparam int unsigned DEF_WIDTH  = 4;
  localparam int unsigned DEF_DWELL  = 4;

  // Controller state: HOLD means a sample is presented and not yet accepted
  typedef enum logic [1:0] {
    MANUAL = 2'd0,
    SCAN   = 2'd1,
    HOLD   = 2'd2
  } state_e;

endpackage

// File: rtl/chan_sel_mux.sv
// Combinational NUM_CH-to-1 channel selector; out-of-range selects map to channel 0.
module chan_sel_mux #(
  parameter int unsigned NUM_CH = 8,
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned CW     = 3
) (
  input  logic [NUM_CH*WIDTH-1:0] data_i,
  input  logic [CW-1:0]           sel_i,
  output logic [WIDTH-1:0]        data_c,
  output logic [CW-1:0]           ch_c
);

  // Channel 0 is the fallback; any matching in-range index overrides it
  always_comb begin
    data_c = data_i[WIDTH-1:0];
    ch_c   = '0;
    for (int k = 1; k < int'(NUM_CH); k++) begin
      if (sel_i == CW'(k)) begin
        data_c = data_i[k*WIDTH +: WIDTH];
        ch_c   = CW'(k);
      end
    end
  end

endmodule

// File: rtl/chan_scan_mux.sv
// Channel scan multiplexer: manual or periodic-scan sampling of NUM_CH channels
// with a valid/ready output that stalls the scan while a sample is pending.
// Optional feature macro: CHAN_SCAN_MUX_MASK_EN adds a per-channel scan enable mask.
module chan_scan_mux
  import chan_scan_pkg::*;
#(
  parameter int unsigned NUM_CH = DEF_NUM_CH,
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned DWELL  = DEF_DWELL,
  localparam int unsigned CW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_CH*WIDTH-1:0] data_in,
  input  logic [CW-1:0]           sel,
  input  logic                    load,
  input  logic                    mode,
  input  logic                    out_ready,
`ifdef CHAN_SCAN_MUX_MASK_EN
  input  logic [NUM_CH-1:0]       ch_mask,
`endif
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic [CW-1:0]           out_ch
);

  localparam int unsigned CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CW-1:0]     ptr_q, ptr_d;
  logic              valid_q, valid_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic [CW-1:0]     ch_q, ch_d;

  logic              stall_c;
  logic              scan_c;
  logic              cnt_last_c;
  logic              ptr_en_c;
  logic [CW-1:0]     nxt_ptr_c;
  logic [CW-1:0]     mux_sel_c;
  logic [WIDTH-1:0]  mux_data_c;
  logic [CW-1:0]     mux_ch_c;

  // A pending sample that the consumer refuses freezes everything
  assign stall_c    = (state_q == HOLD) && !out_ready;
  assign scan_c     = !stall_c && mode;
  assign cnt_last_c = (cnt_q == CNT_W'(DWELL - 1));
  assign mux_sel_c  = scan_c ? ptr_q : sel;

  chan_sel_mux #(
    .NUM_CH (NUM_CH),
    .WIDTH  (WIDTH),
    .CW     (CW)
  ) u_sel (
    .data_i (data_in),
    .sel_i  (mux_sel_c),
    .data_c (mux_data_c),
    .ch_c   (mux_ch_c)
  );

`ifdef CHAN_SCAN_MUX_MASK_EN
  // Current-channel enable and next enabled channel (with wrap); holds if none
  always_comb begin
    int  idx;
    logic found;
    ptr_en_c  = 1'b0;
    nxt_ptr_c = ptr_q;
    found     = 1'b0;
    idx       = 0;
    for (int k = 0; k < int'(NUM_CH); k++) begin
      if (ptr_q == CW'(k)) begin
        ptr_en_c = ch_mask[k];
      end
    end
    for (int k = 1; k < int'(NUM_CH); k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= int'(NUM_CH)) begin
        idx = idx - int'(NUM_CH);
      end
      if (!found && ch_mask[idx]) begin
        nxt_ptr_c = CW'(idx);
        found     = 1'b1;
      end
    end
  end
`else
  // Every channel is scanned; pointer wraps from the last channel to 0
  assign ptr_en_c  = 1'b1;
  assign nxt_ptr_c = (ptr_q == CW'(NUM_CH - 1)) ? '0 : ptr_q + CW'(1);
`endif

  // Next-state, dwell counter, channel pointer and output sample selection
  always_comb begin
    logic capture;
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    valid_d = valid_q;
    data_d  = data_q;
    ch_d    = ch_q;
    capture = 1'b0;

    if (!stall_c) begin
      if (scan_c) begin
        if (cnt_last_c) begin
          cnt_d   = '0;
          ptr_d   = nxt_ptr_c;
          capture = ptr_en_c;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end else begin
        // Manual operation keeps the scan position parked at channel 0,
        // so a later switch to scan always starts from a clean position.
        cnt_d   = '0;
        ptr_d   = '0;
        capture = load;
      end
      valid_d = capture;
      if (capture) begin
        data_d = mux_data_c;
        ch_d   = mux_ch_c;
      end
    end

    case (state_q)
      HOLD: begin
        if (!stall_c) begin
          state_d = valid_d ? HOLD : (mode ? SCAN : MANUAL);
        end
      end
      MANUAL, SCAN: begin
        state_d = valid_d ? HOLD : (mode ? SCAN : MANUAL);
      end
      default: begin
        state_d = MANUAL;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= MANUAL;
      cnt_q   <= '0;
      ptr_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      ch_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      ch_q    <= ch_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_ch    = ch_q;

endmodule

// File: tb/tb_chan_scan_mux.sv
// Self-checking bench for chan_scan_mux: directed scenarios plus randomized
// traffic compared against a behavioural model of the sampling rules.
module tb_chan_scan_mux;

  localparam int NUM_CH = 8;
  localparam int WIDTH  = 4;
  localparam int DWELL  = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data_in;
  logic [2:0]  sel;
  logic        load, mode, ready;
  logic [7:0]  mask;
  logic        out_valid;
  logic [3:0]  out_data;
  logic [2:0]  out_ch;

  // Second instance with six channels for the out-of-range select rule
  logic [23:0] data2;
  logic [2:0]  sel2;
  logic        load2;
  logic        valid2;
  logic [3:0]  d2;
  logic [2:0]  c2;

  int n_checks = 0;
  int n_pass   = 0;

  int m_valid, m_data, m_ch, m_ptr, m_cnt;

  always #5 clk = ~clk;

  chan_scan_mux #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .DWELL(DWELL)) dut (
    .clock     (clk),
    .reset     (rst),
    .data_in   (data_in),
    .sel       (sel),
    .load      (load),
    .mode      (mode),
    .out_ready (ready),
`ifdef CHAN_SCAN_MUX_MASK_EN
    .ch_mask   (mask),
`endif
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ch    (out_ch)
  );

  chan_scan_mux #(.NUM_CH(6), .WIDTH(4), .DWELL(4)) dut6 (
    .clock     (clk),
    .reset     (rst),
    .data_in   (data2),
    .sel       (sel2),
    .load      (load2),
    .mode      (1'b0),
    .out_ready (1'b1),
`ifdef CHAN_SCAN_MUX_MASK_EN
    .ch_mask   (6'h3F),
`endif
    .out_valid (valid2),
    .out_data  (d2),
    .out_ch    (c2)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  // Next scan-enabled channel after p, wrapping; stays on p if none other is enabled
  function automatic int next_enabled(input int p);
    for (int k = 1; k < NUM_CH; k++) begin
      if (mask[(p + k) % NUM_CH]) return (p + k) % NUM_CH;
    end
    return p;
  endfunction

  // Behavioural model: one clock edge of the sampling rules
  task automatic model_step();
    bit cap;
    int cc;
    if (rst) begin
      m_valid = 0; m_data = 0; m_ch = 0; m_ptr = 0; m_cnt = 0;
      return;
    end
    if (m_valid == 1 && !ready) return;
    cap = 0;
    cc  = 0;
    if (mode) begin
      if (m_cnt == DWELL - 1) begin
        m_cnt = 0;
        cap   = mask[m_ptr];
        cc    = m_ptr;
        m_ptr = next_enabled(m_ptr);
      end else begin
        m_cnt++;
      end
    end else begin
      m_ptr = 0;
      m_cnt = 0;
      if (load) begin
        cap = 1;
        cc  = (int'(sel) < NUM_CH) ? int'(sel) : 0;
      end
    end
    m_valid = cap ? 1 : 0;
    if (cap) begin
      m_ch   = cc;
      m_data = int'((data_in >> (cc * WIDTH)) & 32'hF);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("valid", int'(out_valid), m_valid);
    chk("data",  int'(out_data),  m_data);
    chk("ch",    int'(out_ch),    m_ch);
  endtask

  initial begin
    int ch_seq[$];
    int t_seq[$];
    int n;
    bit found;

    rst = 1'b1; data_in = '0; sel = '0; load = 1'b0; mode = 1'b0;
    ready = 1'b1; mask = 8'hFF;
    data2 = '0; sel2 = '0; load2 = 1'b0;
    m_valid = 0; m_data = 0; m_ch = 0; m_ptr = 0; m_cnt = 0;

    // Reset held for two cycles
    load = 1'b1; mode = 1'b1; ready = 1'b0;
    tick(); tick();
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_data",  int'(out_data),  0);
    chk("rst_ch",    int'(out_ch),    0);
    rst = 1'b0; load = 1'b0; mode = 1'b0; ready = 1'b1;

    // Manual select of channel 5
    data_in = 32'h00A0_0000;
    sel = 3'd5; load = 1'b1;
    tick();
    chk("man_valid", int'(out_valid), 1);
    chk("man_data",  int'(out_data),  'hA);
    chk("man_ch",    int'(out_ch),    5);
    load = 1'b0;
    tick();
    chk("man_idle", int'(out_valid), 0);

    // Scan with wrap: one sample per dwell, channels in order
    data_in = 32'h7654_3210;
    mode = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (out_valid) begin
        ch_seq.push_back(int'(out_ch));
        t_seq.push_back(i);
      end
    end
    chk("scan_count", (ch_seq.size() >= 9) ? 1 : 0, 1);
    for (int i = 0; i < 9 && i < ch_seq.size(); i++) begin
      chk("scan_ch", ch_seq[i], i % NUM_CH);
      if (i > 0) chk("scan_gap", t_seq[i] - t_seq[i-1], DWELL);
    end

    // Backpressure on a channel-2 sample
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (out_valid && out_ch == 3'd2) found = 1;
    end
    chk("bp_found", int'(found), 1);
    ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_valid", int'(out_valid), 1);
      chk("bp_ch",    int'(out_ch),    2);
      chk("bp_data",  int'(out_data),  2);
    end
    ready = 1'b1;
    n = 0;
    found = 0;
    for (int i = 1; i <= 20 && !found; i++) begin
      tick();
      if (out_valid) begin
        found = 1;
        n = i;
      end
    end
    chk("bp_release_cycles", n, DWELL);
    chk("bp_next_ch", int'(out_ch), 3);

    // Out-of-range select on the six-channel instance
    data2 = 24'h65_4321;
    sel2 = 3'd7; load2 = 1'b1;
    tick();
    chk("oor7_valid", int'(valid2), 1);
    chk("oor7_ch",    int'(c2),     0);
    chk("oor7_data",  int'(d2),     1);
    sel2 = 3'd6;
    tick();
    chk("oor6_ch",   int'(c2), 0);
    chk("oor6_data", int'(d2), 1);
    sel2 = 3'd3;
    tick();
    chk("in3_ch",   int'(c2), 3);
    chk("in3_data", int'(d2), 4);
    load2 = 1'b0;
    tick();
    chk("oor_idle", int'(valid2), 0);

`ifdef CHAN_SCAN_MUX_MASK_EN
    // Masked scan skips disabled channels, then an empty mask stops sampling
    rst = 1'b1; tick(); rst = 1'b0;
    mask = 8'b1000_0101;
    mode = 1'b1; ready = 1'b1; data_in = 32'h7654_3210;
    ch_seq.delete();
    for (int i = 0; i < 40 && ch_seq.size() < 4; i++) begin
      tick();
      if (out_valid) ch_seq.push_back(int'(out_ch));
    end
    chk("mask_count", ch_seq.size(), 4);
    if (ch_seq.size() == 4) begin
      chk("mask_ch0", ch_seq[0], 0);
      chk("mask_ch1", ch_seq[1], 2);
      chk("mask_ch2", ch_seq[2], 7);
      chk("mask_ch3", ch_seq[3], 0);
    end
    mask = 8'h00;
    tick();
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_valid) n++;
    end
    chk("mask_empty", n, 0);
    mask = 8'hFF;
`endif

    // Randomized traffic against the model
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom_range(99) == 0);
      if ($urandom_range(9) == 0) mode = ~mode;
      load    = 1'($urandom);
      sel     = 3'($urandom);
      ready   = ($urandom_range(9) < 7);
      data_in = $urandom;
`ifdef CHAN_SCAN_MUX_MASK_EN
      if ($urandom_range(19) == 0) mask = 8'($urandom);
`endif
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
